// File: rtl/msp_pkg.sv
// MSP v1 shared definitions: framing characters, well-known command codes
// and the response-transmitter state encoding. The PC-side sniffer uses the same constants.
package msp_pkg;

    localparam logic [7:0] MSP_PREAMBLE0           = 8'h24;  // '$'
    localparam logic [7:0] MSP_PREAMBLE1           = 8'h4D;  // 'M'
    localparam logic [7:0] MSP_DIR_TO_FC           = 8'h3C;  // '<'
    localparam logic [7:0] MSP_DIR_FROM_FC         = 8'h3E;  // '>'
    localparam logic [7:0] MSP_DIR_ERR             = 8'h21;  // '!'
    localparam logic [7:0] MSP_CMD_SET_PASSTHROUGH = 8'hF5;
    localparam logic [7:0] MSP_CMD_IDENT           = 8'h64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_DIR     = 3'd3,
        ST_LEN     = 3'd4,
        ST_CMD     = 3'd5,
        ST_PAYLOAD = 3'd6,
        ST_CKSUM   = 3'd7
    } msp_tx_state_t;

endpackage

// File: rtl/msp_response_tx.sv
// MSP v1 response framer (FC -> PC). Captures a command/length/payload on a
// single-cycle request and streams "$M>" or "$M!", len, cmd, payload and the
// XOR checksum one byte at a time over a valid/ready handshake to the UART.
module msp_response_tx
    import msp_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   rsp_req_i,
    input  logic                   rsp_err_i,
    input  logic [7:0]             rsp_cmd_i,
    input  logic [LEN_W-1:0]       rsp_len_i,
    input  logic [MAX_LEN*8-1:0]   rsp_payload_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overrun_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    // Zero-extend a length value to the 8-bit LEN field.
    function automatic logic [7:0] len_to_byte(input logic [LEN_W-1:0] l);
        logic [7:0] b;
        b = 8'h00;
        b[LEN_W-1:0] = l;
        return b;
    endfunction

    msp_tx_state_t          r_state;
    msp_tx_state_t          w_state_nxt;
    logic                   r_err;
    logic [7:0]             r_cmd;
    logic [LEN_W-1:0]       r_len;
    logic [MAX_LEN*8-1:0]   r_payload;
    logic [7:0]             r_cksum;
    logic [LEN_W-1:0]       r_idx;
    logic                   r_done;
    logic                   r_overrun;

    logic                   w_start;
    logic                   w_accept;
    logic                   w_last_pay;
    logic [LEN_W-1:0]       w_len_clamped;

    assign w_start       = rsp_req_i && (r_state == ST_IDLE);
    assign w_accept      = tx_valid_o && tx_ready_i;
    assign w_last_pay    = ((r_idx + ONE_L) == r_len);
    assign w_len_clamped = (rsp_len_i > MAX_LEN_L) ? MAX_LEN_L : rsp_len_i;

    assign done_o    = r_done;
    assign overrun_o = r_overrun;

    // State register; reset aborts any frame and drops tx_valid_o at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and byte mux: each state holds its byte until accepted.
    always_comb begin
        w_state_nxt = r_state;
        tx_data_o   = 8'h00;
        tx_valid_o  = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rsp_req_i) begin
                    w_state_nxt = ST_HDR0;
                end
            end
            ST_HDR0: begin
                tx_data_o  = MSP_PREAMBLE0;
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = ST_HDR1;
                end
            end
            ST_HDR1: begin
                tx_data_o  = MSP_PREAMBLE1;
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = ST_DIR;
                end
            end
            ST_DIR: begin
                tx_data_o  = r_err ? MSP_DIR_ERR : MSP_DIR_FROM_FC;
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                tx_data_o  = len_to_byte(r_len);
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                tx_data_o  = r_cmd;
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = (r_len != '0) ? ST_PAYLOAD : ST_CKSUM;
                end
            end
            ST_PAYLOAD: begin
                tx_data_o  = r_payload[7:0];
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i && w_last_pay) begin
                    w_state_nxt = ST_CKSUM;
                end
            end
            ST_CKSUM: begin
                tx_data_o  = r_cksum;
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (tx_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Checksum, payload index, done pulse and sticky overrun flag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cksum   <= 8'h00;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= (r_state == ST_CKSUM) && w_accept;
            if (rsp_req_i && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (rsp_req_i) begin
                        r_cksum <= 8'h00;
                        r_idx   <= '0;
                    end
                end
                ST_LEN: begin
                    if (w_accept) begin
                        r_cksum <= len_to_byte(r_len);
                    end
                end
                ST_CMD: begin
                    if (w_accept) begin
                        r_cksum <= r_cksum ^ r_cmd;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_cksum <= r_cksum ^ r_payload[7:0];
                        r_idx   <= r_idx + ONE_L;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request capture; the payload shifts down so the current byte is always bits [7:0].
    always_ff @(posedge wb_clk_i) begin
        if (w_start) begin
            r_err     <= rsp_err_i;
            r_cmd     <= rsp_cmd_i;
            r_len     <= w_len_clamped;
            r_payload <= rsp_payload_i;
        end else if ((r_state == ST_PAYLOAD) && w_accept) begin
            r_payload <= r_payload >> 8;
        end
    end

endmodule

// File: tb/tb_msp_response_tx.sv
// Self-checking bench for msp_response_tx: expected bytes are queued when a
// request is driven and popped as the framer hands bytes to the UART.
module tb_msp_response_tx;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic                  wb_clk_i = 1'b0;
    logic                  wb_rst_ni = 1'b0;
    logic                  rsp_req_i = 1'b0;
    logic                  rsp_err_i = 1'b0;
    logic [7:0]            rsp_cmd_i = 8'h00;
    logic [LEN_W-1:0]      rsp_len_i = '0;
    logic [MAX_LEN*8-1:0]  rsp_payload_i = '0;
    logic [7:0]            tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i = 1'b1;
    logic                  busy_o;
    logic                  done_o;
    logic                  overrun_o;

    logic [7:0] q[$];
    int n_chk  = 0;
    int n_pass = 0;

    msp_response_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .rsp_req_i     (rsp_req_i),
        .rsp_err_i     (rsp_err_i),
        .rsp_cmd_i     (rsp_cmd_i),
        .rsp_len_i     (rsp_len_i),
        .rsp_payload_i (rsp_payload_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overrun_o     (overrun_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Drive a one-cycle request at the current falling edge and queue the expected frame.
    task automatic send_req(input logic err, input logic [7:0] cmd,
                            input logic [LEN_W-1:0] len, input logic [MAX_LEN*8-1:0] pay);
        int l;
        logic [7:0] ck;
        logic [7:0] b;
        l = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        q.push_back(8'h24);
        q.push_back(8'h4D);
        q.push_back(err ? 8'h21 : 8'h3E);
        q.push_back(8'(l));
        q.push_back(cmd);
        ck = 8'(l) ^ cmd;
        for (int i = 0; i < l; i++) begin
            b = pay[8*i +: 8];
            q.push_back(b);
            ck = ck ^ b;
        end
        q.push_back(ck);
        rsp_err_i     = err;
        rsp_cmd_i     = cmd;
        rsp_len_i     = len;
        rsp_payload_i = pay;
        rsp_req_i     = 1'b1;
        @(negedge wb_clk_i);
        rsp_req_i     = 1'b0;
        rsp_cmd_i     = 8'hEE;
        rsp_payload_i = '1;
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        n_chk++;
        if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || overrun_o !== 1'b0)
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b ovr=%b, required 0 00 0 0 0",
                     tx_valid_o, tx_data_o, busy_o, done_o, overrun_o);
        else n_pass++;
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
    endtask

    task automatic test_passthrough_ack();
        int cyc;
        logic [7:0] exp;
        tx_ready_i = 1'b1;
        send_req(1'b0, 8'hF5, LEN_W'(1), 64'h04);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL pt_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (cyc !== 7) $display("FAIL pt_cycles: frame took %0d cycles, required 7", cyc);
        else n_pass++;
        n_chk++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || tx_valid_o !== 1'b0)
            $display("FAIL pt_done: done=%b busy=%b valid=%b, required 1 0 0", done_o, busy_o, tx_valid_o);
        else n_pass++;
        @(negedge wb_clk_i);
        n_chk++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL pt_done_pulse: done=%b busy=%b, required 0 0", done_o, busy_o);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        int cyc;
        logic [7:0] exp;
        send_req(1'b0, 8'h64, LEN_W'(0), 64'hDEAD_BEEF_0000_0011);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL zl_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (cyc !== 6 || done_o !== 1'b1)
            $display("FAIL zl_length: cycles=%0d done=%b, required 6 1", cyc, done_o);
        else n_pass++;
        @(negedge wb_clk_i);
    endtask

    task automatic test_error_backpressure();
        int cyc;
        logic pend;
        logic [7:0] held;
        logic [7:0] exp;
        send_req(1'b1, 8'h10, LEN_W'(2), 64'h55AA);
        cyc = 0;
        pend = 1'b0;
        held = 8'h00;
        while (q.size() > 0 && cyc < 300) begin
            if (pend) begin
                n_chk++;
                if (tx_valid_o !== 1'b1 || tx_data_o !== held)
                    $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", tx_valid_o, tx_data_o, held);
                else n_pass++;
            end
            tx_ready_i = 1'($urandom_range(0, 1));
            pend = tx_valid_o && !tx_ready_i;
            held = tx_data_o;
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL bp_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (q.size() !== 0) $display("FAIL bp_timeout: %0d bytes missing, required 0", q.size());
        else n_pass++;
        tx_ready_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        n_chk++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL bp_idle: valid=%b busy=%b, required 0 0", tx_valid_o, busy_o);
        else n_pass++;
    endtask

    task automatic test_overrun_clamp();
        int cyc;
        logic [7:0] exp;
        send_req(1'b0, 8'h11, LEN_W'(3), 64'h030201);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (cyc == 3) begin
                rsp_cmd_i = 8'h99;
                rsp_len_i = LEN_W'(5);
                rsp_req_i = 1'b1;
            end else begin
                rsp_req_i = 1'b0;
            end
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL ovr_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        rsp_req_i = 1'b0;
        n_chk++;
        if (overrun_o !== 1'b1 || done_o !== 1'b1)
            $display("FAIL ovr_flag: overrun=%b done=%b, required 1 1", overrun_o, done_o);
        else n_pass++;
        @(negedge wb_clk_i);
        n_chk++;
        if (tx_valid_o !== 1'b0) $display("FAIL ovr_no_frame: valid=%b, required 0", tx_valid_o);
        else n_pass++;
        send_req(1'b0, 8'h64, LEN_W'(MAX_LEN + 3), 64'h8877_6655_4433_2211);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL clamp_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (cyc !== 6 + MAX_LEN || overrun_o !== 1'b1)
            $display("FAIL clamp_len: cycles=%0d overrun=%b, required %0d 1", cyc, overrun_o, 6 + MAX_LEN);
        else n_pass++;
        @(negedge wb_clk_i);
    endtask

    task automatic test_reset_mid_payload();
        int cyc;
        int acc;
        logic [7:0] exp;
        send_req(1'b0, 8'h20, LEN_W'(4), 64'h44_3322_11);
        cyc = 0;
        acc = 0;
        while (acc < 6 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                acc++;
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL rst_byte: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (tx_valid_o !== 1'b1 || busy_o !== 1'b1 || overrun_o !== 1'b1)
            $display("FAIL rst_pre: valid=%b busy=%b overrun=%b, required 1 1 1", tx_valid_o, busy_o, overrun_o);
        else n_pass++;
        #2 wb_rst_ni = 1'b0;
        #1;
        n_chk++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0)
            $display("FAIL rst_async: valid=%b busy=%b overrun=%b, required 0 0 0", tx_valid_o, busy_o, overrun_o);
        else n_pass++;
        q.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        send_req(1'b0, 8'hF5, LEN_W'(1), 64'h04);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL rst_after: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (done_o !== 1'b1 || q.size() !== 0)
            $display("FAIL rst_after_done: done=%b left=%0d, required 1 0", done_o, q.size());
        else n_pass++;
        @(negedge wb_clk_i);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] exp;
        send_req(1'b0, 8'hF5, LEN_W'(1), 64'h04);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL b2b_first: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (done_o !== 1'b1) $display("FAIL b2b_done: done=%b, required 1", done_o);
        else n_pass++;
        send_req(1'b0, 8'h64, LEN_W'(2), 64'hBBAA);
        n_chk++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h24 || overrun_o !== 1'b0)
            $display("FAIL b2b_start: valid=%b data=%h overrun=%b, required 1 24 0",
                     tx_valid_o, tx_data_o, overrun_o);
        else n_pass++;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (tx_valid_o && tx_ready_i) begin
                exp = q.pop_front();
                n_chk++;
                if (tx_data_o !== exp) $display("FAIL b2b_second: got %h, required %h", tx_data_o, exp);
                else n_pass++;
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        n_chk++;
        if (done_o !== 1'b1 || overrun_o !== 1'b0 || q.size() !== 0)
            $display("FAIL b2b_end: done=%b overrun=%b left=%0d, required 1 0 0", done_o, overrun_o, q.size());
        else n_pass++;
        @(negedge wb_clk_i);
    endtask

    initial begin
        @(negedge wb_clk_i);
        test_reset();
        test_passthrough_ack();
        test_zero_len();
        test_error_backpressure();
        test_overrun_clamp();
        test_reset_mid_payload();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
